cmp_sort_ctrl: RTL and testbench
================================

Name: cmp_sort_ctrl

Overview:
- Sequential in-place ascending sorter for N 4-bit values.
- Time-shares a single comparator_4bit instance, one compare-and-swap per clock (bubble sort with early exit).
- Host loads values through a write port, pulses start, waits for done, then reads the sorted values back.
- Sits beside the comparator datapath as its scheduler/sequencer.

Parameters:
- N, 4, number of stored elements; legal range 2..16.
- AW, $clog2(N), address width for the write and read ports; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; honoured only in IDLE.
- wr_addr  in  AW  element index to write.
- wr_data  in  4  unsigned value to write.
- start  in  1  begin sort; sampled only in IDLE.
- rd_addr  in  AW  element index to read.
- rd_data  out  4  combinational read of mem[rd_addr].
- busy  out  1  high while in SORT.
- done  out  1  one-cycle pulse when the sort completes.
- swap_count  out  8  number of swaps in the last sort; cleared at each start.
- cmp_count  out  8  number of compare cycles in the last sort; cleared at each start.

Behaviour:
- Reset (async, active-high): all mem entries = 0, state = IDLE, idx = 0, swapped = 0, busy = 0, done = 0, swap_count = 0, cmp_count = 0.
- Storage: N x 4-bit registers. rd_data is always valid, including during SORT, and shows the in-progress contents.
- States: IDLE, SORT, DONE.
- IDLE:
  - wr_en writes mem[wr_addr] <= wr_data.
  - wr_addr >= N is ignored.
  - If start and wr_en are both high in the same cycle, the write commits and the sort begins next cycle on the updated data.
  - start moves to SORT with idx = 0, swapped = 0, and both counters cleared.
- SORT, one compare per cycle:
  - Comparator inputs: a = mem[idx], b = mem[idx+1].
  - If a_gt_b: swap the two entries at the clock edge, set swapped, increment swap_count.
  - If a_eq_b or a_lt_b: no swap. Equal values are never swapped, so the sort is stable.
  - cmp_count increments every SORT cycle.
- End of pass (idx == N-2):
  - If no swap occurred in this pass (including this cycle's compare), go to DONE.
  - Otherwise set idx = 0, clear swapped, and stay in SORT.
- Otherwise idx increments by 1.
- DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE unconditionally.
- busy is high in every SORT cycle and low otherwise.
- Counters hold their values after DONE until the next start.
- Latency:
  - P = number of passes, including the final clean pass; P <= N.
  - SORT lasts P*(N-1) cycles.
  - done asserts in the cycle after the last compare.
  - With start sampled at edge 0, the first compare occurs in cycle 1.
- Ignored inputs:
  - wr_en and start during SORT or DONE have no effect and are not queued.
- Reset mid-sort: returns immediately to the reset state. Partially sorted contents are discarded (cleared to 0). done is not asserted.
- Counters saturate at 255. This is unreachable for N <= 16 but still required.

Test Plan:
- Load [1,2,3,4] at addr 0..3, pulse start → 3 compare cycles, done 4 cycles after start, swap_count=0, cmp_count=3, contents unchanged.
- Load [15,7,2,0], start → sorted [0,2,7,15], swap_count=6, cmp_count=12 (4 passes), busy high exactly 12 cycles.
- Load [3,3,1,3], start → [1,3,3,3], swap_count=2, cmp_count=9; the equal pair (3,3) is never swapped.
- Load [9,4,12,1], start; assert wr_en (addr 0, data 5) and start again during SORT → result [1,4,9,12], write ignored, only one done pulse.
- Load [15,7,2,0], start, assert rst on the 5th SORT cycle → outputs go to 0 immediately, rd_data=0 at all addresses, no done pulse; a new load of [2,1,0,3] plus start yields [0,1,2,3].
- Same-cycle wr_en (addr 3, data 0) with start on [5,6,7,8] → sort operates on [5,6,7,0], result [0,5,6,7], swap_count=3.

Source files
------------

// File: rtl/cmp_sort_ctrl.sv
// Sequential ascending bubble sorter for N 4-bit values that time-shares one comparator.
// The host writes values while idle, pulses start, waits for done, then reads the sorted values back.

module comparator_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       a_gt_b,
   output logic       a_eq_b,
   output logic       a_lt_b
);
   assign a_gt_b = (a > b);
   assign a_eq_b = (a == b);
   assign a_lt_b = (a < b);
endmodule

module cmp_sort_ctrl #(
   parameter  int N  = 4,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_data,
   input  logic          start,
   input  logic [AW-1:0] rd_addr,
   output logic [3:0]    rd_data,
   output logic          busy,
   output logic          done,
   output logic [7:0]    swap_count,
   output logic [7:0]    cmp_count
);
   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t        state;
   state_t        next_state;
   logic [3:0]    mem [N];
   logic [AW-1:0] idx;
   logic [AW-1:0] idx_p1;
   logic          swapped;
   logic [3:0]    cmp_a;
   logic [3:0]    cmp_b;
   logic          a_gt_b;
   logic          a_eq_b;
   logic          a_lt_b;
   logic          do_swap;
   logic          last_pair;
   logic          pass_dirty;

   assign idx_p1 = idx + 1'b1;
   assign cmp_a  = mem[idx];
   assign cmp_b  = mem[idx_p1];

   comparator_4bit u_cmp (
      .a      (cmp_a),
      .b      (cmp_b),
      .a_gt_b (a_gt_b),
      .a_eq_b (a_eq_b),
      .a_lt_b (a_lt_b)
   );

   // Equal or ordered pairs veto the swap, so equal keys keep their order (stable sort).
   assign do_swap    = a_gt_b & ~(a_eq_b | a_lt_b);
   assign last_pair  = (idx == AW'(N - 2));
   assign pass_dirty = swapped | do_swap;

   assign rd_data = (int'(rd_addr) < N) ? mem[rd_addr] : 4'd0;
   assign busy    = (state == SORT);
   assign done    = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = SORT;
         SORT:    if (last_pair && !pass_dirty) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Storage, pass index and statistics; a clean final pass ends the sort early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         swapped    <= 1'b0;
         swap_count <= 8'd0;
         cmp_count  <= 8'd0;
         for (int i = 0; i < N; i++) begin
            mem[i] <= 4'd0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (wr_en && (int'(wr_addr) < N)) begin
                  mem[wr_addr] <= wr_data;
               end
               if (start) begin
                  idx        <= '0;
                  swapped    <= 1'b0;
                  swap_count <= 8'd0;
                  cmp_count  <= 8'd0;
               end
            end
            SORT: begin
               if (do_swap) begin
                  mem[idx]    <= cmp_b;
                  mem[idx_p1] <= cmp_a;
                  if (swap_count != 8'hFF) begin
                     swap_count <= swap_count + 8'd1;
                  end
               end
               if (cmp_count != 8'hFF) begin
                  cmp_count <= cmp_count + 8'd1;
               end
               if (last_pair) begin
                  idx     <= '0;
                  swapped <= 1'b0;
               end else begin
                  idx     <= idx_p1;
                  swapped <= pass_dirty;
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl: loads are checked against a model built on a plain
// sort, the inversion count and the largest left displacement of any element.
`timescale 1ns/1ps

module tb_cmp_sort_ctrl;
   localparam int N       = 4;
   localparam int AW      = $clog2(N);
   localparam int TIMEOUT = 200;

   typedef struct {
      logic [4*N-1:0] vals;
      int             swaps;
      int             cmps;
      longint         start_cyc;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_data;
   logic          start;
   logic [AW-1:0] rd_addr;
   logic [3:0]    rd_data;
   logic          busy;
   logic          done;
   logic [7:0]    swap_count;
   logic [7:0]    cmp_count;

   exp_t       sb [$];
   exp_t       mon_exp;
   logic [3:0] model_mem [N];
   int         check_count = 0;
   int         pass_count  = 0;
   int         done_count  = 0;
   int         busy_cycles = 0;
   longint     cyc         = 0;
   bit         finish_req  = 1'b0;

   cmp_sort_ctrl #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .swap_count (swap_count),
      .cmp_count  (cmp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Sorted contents come from a library sort; bubble-sort swaps equal the inversion count and
   // the number of passes is one more than the furthest any element must travel left.
   function automatic exp_t refModel(input logic [3:0] v [N], input longint s_cyc);
      exp_t e;
      int   q [$];
      int   inv;
      int   max_left;
      int   left;
      inv      = 0;
      max_left = 0;
      for (int i = 0; i < N; i++) q.push_back(int'(v[i]));
      q.sort();
      for (int i = 0; i < N; i++) e.vals[4*i +: 4] = 4'(q[i]);
      for (int i = 0; i < N; i++) begin
         left = 0;
         for (int j = 0; j < i; j++) if (v[j] > v[i]) left++;
         inv += left;
         if (left > max_left) max_left = left;
      end
      e.swaps     = (inv > 255) ? 255 : inv;
      e.cmps      = ((max_left + 1) * (N - 1) > 255) ? 255 : (max_left + 1) * (N - 1);
      e.start_cyc = s_cyc;
      return e;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual == expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: the only process that compares, reads rd_data or pops the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         busy_cycles = 0;
         checkOutput("rst_busy", int'(busy), 0);
         checkOutput("rst_done", int'(done), 0);
         checkOutput("rst_swap_count", int'(swap_count), 0);
         checkOutput("rst_cmp_count", int'(cmp_count), 0);
         for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            checkOutput($sformatf("rst_mem%0d", i), int'(rd_data), 0);
         end
      end else begin
         if (busy) busy_cycles++;
         if (done) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               mon_exp = sb.pop_front();
               checkOutput("swap_count", int'(swap_count), mon_exp.swaps);
               checkOutput("cmp_count", int'(cmp_count), mon_exp.cmps);
               checkOutput("busy_cycles", busy_cycles, mon_exp.cmps);
               checkOutput("done_latency", int'(cyc - mon_exp.start_cyc), mon_exp.cmps);
               for (int i = 0; i < N; i++) begin
                  rd_addr = AW'(i);
                  #1;
                  checkOutput($sformatf("sorted_mem%0d", i), int'(rd_data),
                              int'(mon_exp.vals[4*i +: 4]));
               end
               busy_cycles = 0;
               done_count++;
            end
         end else if (sb.size() > 0 && (cyc - sb[0].start_cyc) > TIMEOUT) begin
            checkOutput("done_timeout", 0, 1);
            void'(sb.pop_front());
            busy_cycles = 0;
            done_count++;
         end
         if (finish_req) begin
            checkOutput("scoreboard_empty", sb.size(), 0);
            $display("%0d/%0d checks passed", pass_count, check_count);
            $finish;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic loadVals(input logic [4*N-1:0] vals);
      for (int i = 0; i < N; i++) begin
         wr_en        = 1'b1;
         wr_addr      = AW'(i);
         wr_data      = vals[4*i +: 4];
         model_mem[i] = vals[4*i +: 4];
         tick();
      end
      wr_en = 1'b0;
   endtask

   // noise: 0 none, 1 one write+start on the 2nd SORT cycle, 2 random writes/starts while busy.
   // abort_cycle > 0 asserts reset in that SORT cycle instead of waiting for done.
   task automatic applyStimulus(input bit sc_wr, input logic [AW-1:0] sc_addr,
                                input logic [3:0] sc_data, input int noise, input int abort_cycle);
      int target;
      int busy_seen;
      exp_t e;
      target = done_count + 1;
      start  = 1'b1;
      if (sc_wr) begin
         wr_en              = 1'b1;
         wr_addr            = sc_addr;
         wr_data            = sc_data;
         model_mem[sc_addr] = sc_data;
      end
      e = refModel(model_mem, cyc + 1);
      sb.push_back(e);
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (abort_cycle > 0) begin
         repeat (abort_cycle - 1) tick();
         #2 rst = 1'b1;
         tick();
         tick();
         rst = 1'b0;
         for (int i = 0; i < N; i++) model_mem[i] = 4'd0;
         return;
      end
      busy_seen = 0;
      for (int t = 0; t < TIMEOUT + 20 && done_count < target; t++) begin
         if (busy) begin
            busy_seen++;
            if (noise == 1 && busy_seen == 2) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               wr_data = 4'd5;
               start   = 1'b1;
            end else if (noise == 2) begin
               wr_en   = 1'($urandom_range(0, 1));
               wr_addr = AW'($urandom_range(0, N - 1));
               wr_data = 4'($urandom_range(0, 15));
               start   = 1'($urandom_range(0, 1));
            end else begin
               wr_en = 1'b0;
               start = 1'b0;
            end
         end else begin
            wr_en = 1'b0;
            start = 1'b0;
         end
         tick();
      end
      wr_en = 1'b0;
      start = 1'b0;
      for (int i = 0; i < N; i++) model_mem[i] = e.vals[4*i +: 4];
   endtask

   initial begin
      logic [4*N-1:0] rv;
      int             hi;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = 4'd0;
      start   = 1'b0;
      for (int i = 0; i < N; i++) model_mem[i] = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      loadVals(16'h4321);
      applyStimulus(1'b0, '0, 4'd0, 0, 0);
      loadVals(16'h027F);
      applyStimulus(1'b0, '0, 4'd0, 0, 0);
      loadVals(16'h3133);
      applyStimulus(1'b0, '0, 4'd0, 0, 0);
      loadVals(16'h1C49);
      applyStimulus(1'b0, '0, 4'd0, 1, 0);
      loadVals(16'h027F);
      applyStimulus(1'b0, '0, 4'd0, 0, 5);
      tick();
      loadVals(16'h3012);
      applyStimulus(1'b0, '0, 4'd0, 0, 0);
      loadVals(16'h8765);
      applyStimulus(1'b1, AW'(3), 4'd0, 0, 0);
      applyStimulus(1'b0, '0, 4'd0, 0, 0);

      for (int n = 0; n < 30; n++) begin
         hi = ($urandom_range(0, 1) == 1) ? 15 : 3;
         for (int i = 0; i < N; i++) rv[4*i +: 4] = 4'($urandom_range(0, hi));
         loadVals(rv);
         applyStimulus(1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, N - 1)),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? 2 : 0, 0);
      end

      tick();
      finish_req = 1'b1;
      repeat (20) tick();
      $display("[TB] FAIL finish_handshake: monitor did not end the run");
      $fatal(1, "[TB] monitor did not finish");
   end
endmodule
